// File: rtl/coord_sequencer_pkg.sv
// Shared definitions for the Mandelbrot coordinate sequencer: control codes,
// sequencer state encoding and config word field layout.
package coord_defs;

  // Control codes understood by the coordinate block
  localparam logic [2:0] CTRL_SPIN          = 3'b000;
  localparam logic [2:0] CTRL_SET_LEFT      = 3'b001;
  localparam logic [2:0] CTRL_SET_TOP       = 3'b010;
  localparam logic [2:0] CTRL_NONE          = 3'b011;
  localparam logic [2:0] CTRL_SET_INC_COL_X = 3'b100;
  localparam logic [2:0] CTRL_SET_INC_COL_Y = 3'b101;
  localparam logic [2:0] CTRL_SET_INC_ROW_X = 3'b110;
  localparam logic [2:0] CTRL_SET_INC_ROW_Y = 3'b111;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_CFG   = 2'b00,
    ST_START = 2'b01,
    ST_RUN   = 2'b10
  } seq_state_e;

  // Config word layout: [15:13] ctrl code, [12:0] value
  localparam int CFG_W         = 16;
  localparam int CFG_CTRL_MSB  = 15;
  localparam int CFG_CTRL_LSB  = 13;
  localparam int CFG_VALUE_MSB = 12;
  localparam int CFG_VALUE_LSB = 0;

  function automatic logic [2:0] cfg_ctrl(input logic [CFG_W-1:0] word);
    return word[CFG_CTRL_MSB:CFG_CTRL_LSB];
  endfunction

  function automatic logic [12:0] cfg_value(input logic [CFG_W-1:0] word);
    return word[CFG_VALUE_MSB:CFG_VALUE_LSB];
  endfunction

endpackage

// File: rtl/coord_sequencer_cfg_fifo.sv
// Small synchronous FIFO buffering host config words until the sequencer is
// between frames. Push and pop may occur in the same cycle.
module cfg_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] head,
  output logic         full,
  output logic         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [NW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  assign full      = (count_r == NW'(DEPTH));
  assign empty     = (count_r == NW'(0));
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Storage array: written on an accepted push, contents irrelevant when empty
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + NW'(1);
        2'b01:   count_r <= count_r - NW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/coord_sequencer.sv
// Frame sequencer for the Mandelbrot coordinate generator: walks the pixel
// raster, strobes the iterator, and replays buffered config writes only
// between frames so each frame uses one consistent parameter set.
module coord_sequencer
  import coord_defs::*;
#(
  parameter int COLS  = 320,
  parameter int ROWS  = 240,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    run,
  input  logic                    pixel_advance,
  input  logic                    cfg_valid,
  input  logic [15:0]             cfg_data,
  output logic                    cfg_ready,
  output logic [2:0]              ctrl,
  output logic [12:0]             value,
  output logic                    next_row,
  output logic                    next_frame,
  output logic                    coord_load,
  output logic                    frame_done,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] row,
  output logic                    busy
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);

  seq_state_e    state_r;
  logic [CW-1:0] col_r;
  logic [RW-1:0] row_r;

  logic          fifo_push_s;
  logic          fifo_pop_s;
  logic [15:0]   fifo_head_s;
  logic          fifo_full_s;
  logic          fifo_empty_s;
  logic          last_col_s;
  logic          last_row_s;

  assign fifo_push_s = cfg_valid && !fifo_full_s;
  assign fifo_pop_s  = (state_r == ST_CFG) && !fifo_empty_s;
  assign cfg_ready   = !fifo_full_s;
  assign last_col_s  = (col_r == CW'(COLS - 1));
  assign last_row_s  = (row_r == RW'(ROWS - 1));
  assign col         = col_r;
  assign row         = row_r;

  cfg_fifo #(
    .DEPTH (DEPTH),
    .W     (CFG_W)
  ) u_cfg_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .pop   (fifo_pop_s),
    .din   (cfg_data),
    .head  (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Sequencer FSM and raster counters; the same-cycle push keeps us in CFG so
  // a late config word is still replayed ahead of the frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_CFG;
      col_r   <= '0;
      row_r   <= '0;
    end else begin
      case (state_r)
        ST_CFG: begin
          if (fifo_empty_s && !fifo_push_s && run) begin
            state_r <= ST_START;
          end else begin
            state_r <= ST_CFG;
          end
        end
        ST_START: begin
          col_r   <= '0;
          row_r   <= '0;
          state_r <= ST_RUN;
        end
        ST_RUN: begin
          if (pixel_advance) begin
            if (!last_col_s) begin
              col_r <= col_r + CW'(1);
            end else if (!last_row_s) begin
              col_r <= '0;
              row_r <= row_r + RW'(1);
            end else begin
              col_r   <= '0;
              row_r   <= '0;
              state_r <= ST_CFG;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        default: begin
          state_r <= ST_CFG;
          col_r   <= '0;
          row_r   <= '0;
        end
      endcase
    end
  end

  // Output decode from state, FIFO head and the current advance request
  always_comb begin
    ctrl       = CTRL_NONE;
    value      = 13'd0;
    next_row   = 1'b0;
    next_frame = 1'b0;
    coord_load = 1'b0;
    frame_done = 1'b0;
    busy       = 1'b0;
    case (state_r)
      ST_CFG: begin
        if (!fifo_empty_s && (cfg_ctrl(fifo_head_s) != CTRL_NONE)) begin
          ctrl  = cfg_ctrl(fifo_head_s);
          value = cfg_value(fifo_head_s);
        end else begin
          ctrl  = CTRL_NONE;
          value = 13'd0;
        end
      end
      ST_START: begin
        next_frame = 1'b1;
        coord_load = 1'b1;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (pixel_advance) begin
          if (last_col_s && last_row_s) begin
            frame_done = 1'b1;
          end else begin
            coord_load = 1'b1;
            next_row   = last_col_s;
          end
        end else begin
          coord_load = 1'b0;
        end
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_coord_sequencer.sv
// Randomized scoreboard bench for coord_sequencer with a small raster.
module tb_coord_sequencer;

  localparam int COLS  = 4;
  localparam int ROWS  = 3;
  localparam int DEPTH = 4;
  localparam int NPIX  = COLS * ROWS;

  localparam int P_CFG   = 0;
  localparam int P_START = 1;
  localparam int P_RUN   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        run = 1'b0;
  logic        pixel_advance = 1'b0;
  logic        cfg_valid = 1'b0;
  logic [15:0] cfg_data = 16'h0000;
  logic        cfg_ready;
  logic [2:0]  ctrl;
  logic [12:0] value;
  logic        next_row;
  logic        next_frame;
  logic        coord_load;
  logic        frame_done;
  logic [1:0]  col;
  logic [1:0]  row;
  logic        busy;

  coord_sequencer #(.COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .run           (run),
    .pixel_advance (pixel_advance),
    .cfg_valid     (cfg_valid),
    .cfg_data      (cfg_data),
    .cfg_ready     (cfg_ready),
    .ctrl          (ctrl),
    .value         (value),
    .next_row      (next_row),
    .next_frame    (next_frame),
    .coord_load    (coord_load),
    .frame_done    (frame_done),
    .col           (col),
    .row           (row),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w;
    int          c;
  } cfg_ent_t;

  cfg_ent_t    exp_q[$];   // accepted config words, in acceptance order
  logic [15:0] tx_q[$];    // words waiting to be offered
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int frames = 0;
  int m_phase = P_CFG;
  int m_pix = 0;
  logic rst_v = 1'b0;
  logic run_v = 1'b0;
  int   pa_mode = 0;       // 0 idle, 1 every cycle, 2 random
  logic acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: reference model of the frame/config behaviour, compared each cycle
  always @(negedge clk) begin
    int vis;
    int n_phase;
    cfg_ent_t ent;
    logic [2:0]  e_ctrl;
    logic [12:0] e_val;
    logic e_nr, e_nf, e_cl, e_fd, e_busy;
    int e_col, e_row;
    if (!rst_n) begin
      chk("rst_ctrl", ctrl, 3'b011);
      chk("rst_value", value, 13'd0);
      chk("rst_strobes", {next_row, next_frame, coord_load, frame_done}, 4'b0000);
      chk("rst_ready", cfg_ready, 1'b1);
      chk("rst_busy", busy, 1'b0);
      chk("rst_colrow", {col, row}, 4'b0000);
      exp_q.delete();
      m_phase = P_CFG;
      m_pix = 0;
    end else begin
      vis = exp_q.size();
      if (vis > 0 && exp_q[$].c == cyc) vis--;
      e_ctrl = 3'b011; e_val = 13'd0;
      e_nr = 1'b0; e_nf = 1'b0; e_cl = 1'b0; e_fd = 1'b0; e_busy = 1'b0;
      e_col = 0; e_row = 0;
      n_phase = m_phase;
      chk("cfg_ready", cfg_ready, (vis < DEPTH) ? 1 : 0);
      case (m_phase)
        P_CFG: begin
          if (vis > 0) begin
            ent = exp_q.pop_front();
            e_ctrl = ent.w[15:13];
            e_val = (e_ctrl == 3'b011) ? 13'd0 : ent.w[12:0];
          end else if (!cfg_valid && run) begin
            n_phase = P_START;
          end
        end
        P_START: begin
          e_nf = 1'b1;
          e_cl = 1'b1;
          m_pix = 0;
          n_phase = P_RUN;
        end
        default: begin
          e_busy = 1'b1;
          e_col = m_pix % COLS;
          e_row = m_pix / COLS;
          if (pixel_advance) begin
            if (m_pix == NPIX - 1) begin
              e_fd = 1'b1;
              frames++;
              n_phase = P_CFG;
            end else begin
              e_cl = 1'b1;
              e_nr = ((m_pix % COLS) == COLS - 1);
              m_pix++;
            end
          end
        end
      endcase
      chk("ctrl", ctrl, e_ctrl);
      chk("value", value, e_val);
      chk("next_row", next_row, e_nr);
      chk("next_frame", next_frame, e_nf);
      chk("coord_load", coord_load, e_cl);
      chk("frame_done", frame_done, e_fd);
      chk("busy", busy, e_busy);
      chk("col", col, e_col);
      chk("row", row, e_row);
      m_phase = n_phase;
    end
  end

  // One stimulus cycle: drive after the edge, record handshakes before the next
  task automatic step();
    @(posedge clk);
    #1;
    rst_n = rst_v;
    run = run_v;
    if (acc) begin
      cfg_valid = 1'b0;
      acc = 1'b0;
    end
    if (!rst_v) begin
      cfg_valid = 1'b0;
      tx_q.delete();
    end else if (!cfg_valid && tx_q.size() > 0) begin
      cfg_data = tx_q.pop_front();
      cfg_valid = 1'b1;
    end
    case (pa_mode)
      1:       pixel_advance = 1'b1;
      2:       pixel_advance = 1'($urandom_range(0, 1));
      default: pixel_advance = 1'b0;
    endcase
    @(negedge clk);
    if (rst_n && cfg_valid && cfg_ready) begin
      exp_q.push_back('{cfg_data, cyc});
      acc = 1'b1;
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_busy();
    for (int i = 0; i < 100; i++) begin
      if (busy) break;
      step();
    end
    chk("wait_busy", busy, 1'b1);
  endtask

  initial begin
    // Reset, then free-running frames with no config
    rst_v = 1'b0; run_v = 1'b1; pa_mode = 1;
    steps(3);
    rst_v = 1'b1;
    steps(40);

    // Two config words offered mid-frame, replayed only after frame_done
    wait_busy();
    tx_q.push_back(16'h2000 | 16'h0123);
    tx_q.push_back(16'h4000 | 16'h00AA);
    steps(30);

    // Six words while the frame is stalled: FIFO fills and back-pressures
    pa_mode = 0;
    wait_busy();
    for (int i = 0; i < 6; i++) tx_q.push_back(16'($urandom));
    steps(10);
    chk("ready_when_full", cfg_ready, 1'b0);
    pa_mode = 1;
    steps(40);

    // run low at frame end holds the sequencer between frames
    run_v = 1'b0;
    steps(40);
    chk("idle_not_busy", busy, 1'b0);
    run_v = 1'b1;
    steps(20);

    // Reset mid-frame with queued words: words are discarded
    wait_busy();
    pa_mode = 0;
    tx_q.push_back(16'h2000 | 16'h0555);
    tx_q.push_back(16'hE000 | 16'h1FFF);
    steps(4);
    rst_v = 1'b0;
    steps(2);
    rst_v = 1'b1;
    pa_mode = 1;
    steps(30);

    // Randomized traffic
    pa_mode = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) run_v = ~run_v;
      if (tx_q.size() == 0 && $urandom_range(0, 5) == 0) tx_q.push_back(16'($urandom));
      if ($urandom_range(0, 1499) == 0) rst_v = 1'b0;
      else rst_v = 1'b1;
      step();
    end
    run_v = 1'b1;
    steps(60);
    chk("frames_seen", (frames >= 20) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/coord_sequencer.md
# coord_sequencer

Sequences the Mandelbrot coordinate generator for one rendered frame at a time. It walks a COLS×ROWS pixel raster and issues the `next_row`/`next_frame` strobes plus a coordinate-load enable to the iterator. It also buffers host configuration writes (3-bit ctrl + 13-bit value) and replays them onto the coordinate block's `ctrl`/`value` bus only between frames, so every frame renders with one consistent parameter set.

## Interface
- `COLS`, 320, pixels per row (≥2)
- `ROWS`, 240, rows per frame (≥2)
- `DEPTH`, 4, config FIFO entries (power of two, ≥2)
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset; asynchronous assert, active-low
- `run`  in  1  level; 1 permits a new frame to start
- `pixel_advance`  in  1  iterator has consumed current x0/y0 and wants the next coordinate
- `cfg_valid`  in  1  config word offered
- `cfg_data`  in  16  [15:13] ctrl code, [12:0] value
- `cfg_ready`  out  1  FIFO can accept (= not full)
- `ctrl`  out  3  to coordinate block; CTRL_NONE (3'b011) except when replaying
- `value`  out  13  to coordinate block; 0 when ctrl is CTRL_NONE
- `next_row`  out  1  one-cycle strobe: select row start
- `next_frame`  out  1  one-cycle strobe: select frame origin
- `coord_load`  out  1  iterator registers x0/y0 <= next_x0/next_y0 this cycle
- `frame_done`  out  1  one-cycle pulse on acceptance of the last pixel
- `col`  out  $clog2(COLS)  current column
- `row`  out  $clog2(ROWS)  current row
- `busy`  out  1  high in RUN

## Operation
- States: CFG, START, RUN.
- Reset: state CFG, FIFO empty, col=row=0; all strobes 0, ctrl=3'b011, value=0, cfg_ready=1, busy=0.
- CFG:
  - If the FIFO is non-empty, pop the head. Drive ctrl=head[15:13] and value=head[12:0] for exactly that cycle. One entry per cycle.
  - Code 3'b011 consumes a cycle with no effect. All other codes are forwarded verbatim.
  - If the FIFO is empty and run=1, go to START.
  - If the FIFO is empty and run=0, stay in CFG.
- START: assert next_frame and coord_load for one cycle. Set col=0, row=0. Go to RUN.
- RUN, on pixel_advance:
  - col<COLS-1: coord_load, col++.
  - col=COLS-1 and row<ROWS-1: next_row + coord_load, col=0, row++.
  - Last pixel: frame_done, no coord_load, go to CFG.
- pixel_advance is ignored outside RUN.
- ctrl stays 3'b011 in START/RUN, so no register in the coordinate block is written mid-frame.
- FIFO push: cfg_valid && cfg_ready, accepted in any state.
  - Push and pop in the same cycle leaves count unchanged.
  - When full, cfg_ready=0 and the offered word is held by the sender (not dropped).
- next_row and next_frame are never asserted together.

## Timing
- ctrl/value/next_row/next_frame/coord_load/frame_done are decoded from registered state, FIFO head and the current pixel_advance. They are valid in the same cycle and consumed by the coordinate block at the next edge.
- Config latency: word accepted at edge N (FIFO previously empty, state CFG) appears on ctrl at cycle N+1.
- Frame turnaround with empty FIFO and run=1: frame_done at cycle T, CFG at T+1, START (next_frame) at T+2, first RUN cycle T+3.
- With k queued entries: START at T+1+k+1.
- A word pushed during the final CFG cycle is replayed before START, because the empty check uses the current count including the same-cycle push.
- Mid-operation reset (async) returns immediately to reset values, discards FIFO contents and aborts the frame. The first frame after reset starts 2 cycles after deassertion when run=1.

## Structure
- Shared defines/package `coord_defs`:
  - CTRL_* codes (SPIN 000, SET_LEFT 001, SET_TOP 010, NONE 011, SET_INC_COL_X 100, SET_INC_COL_Y 101, SET_INC_ROW_X 110, SET_INC_ROW_Y 111).
  - State encodings.
  - cfg_data field positions.
- Sub-module `cfg_fifo`: synchronous DEPTH×16 FIFO with push/pop/full/empty/head, async active-low reset, same-cycle push/pop.
- Top holds the FSM and raster counters.

## Test plan
- Reset with run=1, no config: next_frame+coord_load at cycle 2 after rst_n rises. Then ctrl stays 3'b011 for a whole frame.
- COLS=4, ROWS=3, pixel_advance every cycle:
  - next_row pulses on advances 4 and 8.
  - frame_done on advance 12.
  - next_frame is 2 cycles later.
  - col/row wrap to 0.
- Push 0x2000|0x123 (SET_LEFT, 0x123) and 0x4000|0x0AA mid-frame:
  - Nothing appears on ctrl during RUN.
  - After frame_done: ctrl=001/value=0x123, then 010/0x0AA on consecutive cycles, then next_frame.
- Offer 6 words with DEPTH=4 while in RUN: cfg_ready drops after 4. The remaining 2 are accepted as CFG drains. All 6 are replayed in order.
- run=0 at frame end: stays in CFG with no next_frame. Raise run: next_frame the cycle after START is entered.
- Assert rst_n low mid-frame with 2 queued words: outputs return to reset values immediately. The words are never replayed, and a new frame starts from col=row=0.
